// File: rtl/comparator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : comparator_pkg
// Description : Shared types and constants for the comparator block.
//               Holds the compare-result encoding, the statistics counter
//               width and a saturating-increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package comparator_pkg;

    // Statistics counter width
    localparam int CNT_W = 16;

    // Result of one operand-pair comparison
    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_LT = 2'd1,
        CMP_GT = 2'd2
    } cmp_res_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/comparator_core.sv
`default_nettype none
// ============================================================================
// Module      : comparator_core
// Description : Purely combinational magnitude compare of a against b.
//               Signed operands are handled by inverting the sign bit, which
//               maps two's-complement order onto unsigned order.
// Revision    : 1.0 - initial release
// ============================================================================
module comparator_core
    import comparator_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_res_e         res
);

    // Only the MSB is flipped, and only for two's-complement operands
    localparam logic [WIDTH-1:0] c_sign_mask = SIGNED ? (WIDTH'(1) << (WIDTH-1)) : '0;

    logic [WIDTH-1:0] w_a_key;
    logic [WIDTH-1:0] w_b_key;

    assign w_a_key = a ^ c_sign_mask;
    assign w_b_key = b ^ c_sign_mask;

    // Unsigned compare of the order-preserving keys
    always_comb begin
        res = CMP_EQ;
        if (w_a_key > w_b_key) begin
            res = CMP_GT;
        end else if (w_a_key < w_b_key) begin
            res = CMP_LT;
        end
    end

endmodule
`default_nettype wire

// File: rtl/comparator.sv
`default_nettype none
// ============================================================================
// Module      : comparator
// Description : Registered comparator with one-cycle latency. Each accepted
//               pair (in_valid high) updates the one-hot greater/lesser/equal
//               flags and pulses out_valid one cycle later; flags hold while
//               idle. Optional saturating result counters are built when the
//               macro COMPARATOR_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef COMPARATOR_STATS_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] cnt_gt,
    output logic [CNT_W-1:0] cnt_lt,
    output logic [CNT_W-1:0] cnt_eq,
`endif
    output logic             greater,
    output logic             lesser,
    output logic             equal,
    output logic             out_valid
);

    cmp_res_e w_res;

    logic r_greater;
    logic r_lesser;
    logic r_equal;
    logic r_out_valid;

    comparator_core #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_core (
        .a   (a),
        .b   (b),
        .res (w_res)
    );

    // Result flags capture each accepted pair and hold while idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_greater   <= 1'b0;
            r_lesser    <= 1'b0;
            r_equal     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_greater <= (w_res == CMP_GT);
                r_lesser  <= (w_res == CMP_LT);
                r_equal   <= (w_res == CMP_EQ);
            end
        end
    end

    assign greater   = r_greater;
    assign lesser    = r_lesser;
    assign equal     = r_equal;
    assign out_valid = r_out_valid;

`ifdef COMPARATOR_STATS_EN
    logic [CNT_W-1:0] r_cnt_gt;
    logic [CNT_W-1:0] r_cnt_lt;
    logic [CNT_W-1:0] r_cnt_eq;

    // Saturating per-result counters; a clear beats a coincident pair
    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            r_cnt_gt <= '0;
            r_cnt_lt <= '0;
            r_cnt_eq <= '0;
        end else if (in_valid) begin
            case (w_res)
                CMP_GT:  r_cnt_gt <= sat_inc(r_cnt_gt);
                CMP_LT:  r_cnt_lt <= sat_inc(r_cnt_lt);
                default: r_cnt_eq <= sat_inc(r_cnt_eq);
            endcase
        end
    end

    assign cnt_gt = r_cnt_gt;
    assign cnt_lt = r_cnt_lt;
    assign cnt_eq = r_cnt_eq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_comparator.sv
`default_nettype none
// ============================================================================
// Module      : tb_comparator
// Description : Self-checking bench for comparator. Six instances cover
//               WIDTH 1/8/16 in both unsigned and signed flavours, driven in
//               lock-step; expected flags/valid/counters are queued when a
//               step is driven and compared one edge later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comparator;

    localparam int c_n = 6;
`ifdef COMPARATOR_STATS_EN
    localparam bit c_stats = 1'b1;
`else
    localparam bit c_stats = 1'b0;
`endif

    typedef struct packed {
        logic                         ov;
        logic [c_n-1:0][2:0]          f;
        logic [c_n-1:0][2:0][15:0]    c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        stats_clr;
    logic [15:0] ain [c_n];
    logic [15:0] bin [c_n];
    logic        gt  [c_n];
    logic        lt  [c_n];
    logic        eq  [c_n];
    logic        ov  [c_n];
`ifdef COMPARATOR_STATS_EN
    logic [15:0] cg  [c_n];
    logic [15:0] cl  [c_n];
    logic [15:0] ce  [c_n];
`endif

    exp_t        q[$];
    logic [2:0]  m_f   [c_n];
    logic [15:0] m_cnt [c_n][3];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    function automatic int wid(input int i);
        return (i < 2) ? 1 : ((i < 4) ? 8 : 16);
    endfunction

    for (genvar g = 0; g < c_n; g++) begin : g_dut
        localparam int W = (g < 2) ? 1 : ((g < 4) ? 8 : 16);
        comparator #(
            .WIDTH  (W),
            .SIGNED ((g % 2) == 1)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .a         (ain[g][W-1:0]),
            .b         (bin[g][W-1:0]),
`ifdef COMPARATOR_STATS_EN
            .stats_clr (stats_clr),
            .cnt_gt    (cg[g]),
            .cnt_lt    (cl[g]),
            .cnt_eq    (ce[g]),
`endif
            .greater   (gt[g]),
            .lesser    (lt[g]),
            .equal     (eq[g]),
            .out_valid (ov[g])
        );
    end

    // Numeric value of an operand as seen by instance i
    function automatic longint val(input int i, input logic [15:0] x);
        longint w;
        longint v;
        w = longint'(wid(i));
        v = longint'(x) & ((64'sd1 <<< w) - 1);
        if ((i % 2) == 1 && v >= (64'sd1 <<< (w - 1))) v = v - (64'sd1 <<< w);
        return v;
    endfunction

    // Reference result as {gt, lt, eq}
    function automatic logic [2:0] model(input int i);
        longint x;
        longint y;
        x = val(i, ain[i]);
        y = val(i, bin[i]);
        return {x > y, x < y, x == y};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_w(input int w, input logic [15:0] x, input logic [15:0] y);
        for (int i = 0; i < c_n; i++) begin
            if (wid(i) == w) begin
                ain[i] = x;
                bin[i] = y;
            end
        end
    endtask

    // Drive one cycle, queue its expectation, then check after the edge
    task automatic step(input logic rv, input logic v, input logic clr);
        exp_t       e;
        logic [2:0] r;
        rst_n     = rv;
        in_valid  = v;
        stats_clr = clr;
        e         = '0;
        for (int i = 0; i < c_n; i++) begin
            r = model(i);
            if (!rv) begin
                m_f[i] = 3'b000;
                for (int k = 0; k < 3; k++) m_cnt[i][k] = 16'h0;
            end else begin
                if (v) m_f[i] = r;
                if (c_stats && clr) begin
                    for (int k = 0; k < 3; k++) m_cnt[i][k] = 16'h0;
                end else if (v) begin
                    for (int k = 0; k < 3; k++)
                        if (r[2-k] && m_cnt[i][k] != 16'hFFFF) m_cnt[i][k] = m_cnt[i][k] + 16'h1;
                end
            end
            e.f[i] = m_f[i];
            for (int k = 0; k < 3; k++) e.c[i][k] = m_cnt[i][k];
        end
        e.ov = rv & v;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        for (int i = 0; i < c_n; i++) begin
            chk($sformatf("flags%0d", i), {13'h0, gt[i], lt[i], eq[i]}, {13'h0, e.f[i]});
            chk($sformatf("out_valid%0d", i), {15'h0, ov[i]}, {15'h0, e.ov});
`ifdef COMPARATOR_STATS_EN
            chk($sformatf("cnt_gt%0d", i), cg[i], e.c[i][0]);
            chk($sformatf("cnt_lt%0d", i), cl[i], e.c[i][1]);
            chk($sformatf("cnt_eq%0d", i), ce[i], e.c[i][2]);
`endif
        end
    endtask

    initial begin
        int n_rand;
        for (int i = 0; i < c_n; i++) begin
            ain[i] = 16'h0;
            bin[i] = 16'h0;
            m_f[i] = 3'b000;
            for (int k = 0; k < 3; k++) m_cnt[i][k] = 16'h0;
        end

        // Reset state, with in_valid asserted and ignored
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        // All four 1-bit pairs
        set_w(1, 16'h0, 16'h0); step(1'b1, 1'b1, 1'b0);
        set_w(1, 16'h0, 16'h1); step(1'b1, 1'b1, 1'b0);
        set_w(1, 16'h1, 16'h0); step(1'b1, 1'b1, 1'b0);
        set_w(1, 16'h1, 16'h1); step(1'b1, 1'b1, 1'b0);

        // Sign-bit boundary at 8 bits and 16 bits
        set_w(8, 16'h80, 16'h7F);
        set_w(16, 16'h8000, 16'h7FFF);
        step(1'b1, 1'b1, 1'b0);

        // Single pair then idle: flags hold, out_valid pulses once
        set_w(8, 16'h5, 16'h3);
        step(1'b1, 1'b1, 1'b0);
        set_w(8, 16'h0, 16'hFF);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        // Reset right after a pair discards it
        set_w(8, 16'h2, 16'h2);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        // First pair after reset
        set_w(1, 16'h0, 16'h1);
        set_w(8, 16'h9, 16'h2);
        set_w(16, 16'h1234, 16'hFFFF);
        step(1'b1, 1'b1, 1'b0);

        // Random traffic; with stats the 1-bit lanes see only equal pairs
        // and every cycle is valid so cnt_eq runs into saturation
        n_rand = c_stats ? 70000 : 10000;
        for (int t = 0; t < n_rand; t++) begin
            logic [15:0] x;
            logic        v;
            x = 16'($urandom);
            if (c_stats) set_w(1, x, x);
            else         set_w(1, x, 16'($urandom));
            set_w(8, 16'($urandom), 16'($urandom));
            set_w(16, 16'($urandom), 16'($urandom));
            v = c_stats ? 1'b1 : ($urandom_range(0, 7) != 0);
            step(1'b1, v, 1'b0);
        end

        // Clear with a coincident pair, then normal counting resumes
        set_w(1, 16'h1, 16'h0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/comparator.md
COMPARATOR -- requirements
Module: comparator

Interface
REQ-001 Parameter WIDTH, default 1, operand width in bits; legal range 1..64.
REQ-002 Parameter SIGNED, default 0; 0 = unsigned magnitude compare, 1 = two's-complement compare.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  high = a/b hold an operand pair to compare this cycle.
REQ-006 a  input  WIDTH  first operand.
REQ-007 b  input  WIDTH  second operand.
REQ-008 greater  output  1  registered; 1 when last accepted a > b.
REQ-009 lesser  output  1  registered; 1 when last accepted a < b.
REQ-010 equal  output  1  registered; 1 when last accepted a == b.
REQ-011 out_valid  output  1  registered; pulses high for one cycle, one cycle after each accepted pair.
REQ-012 stats_clr  input  1  synchronous clear of statistics counters (present only with COMPARATOR_STATS_EN).
REQ-013 cnt_gt, cnt_lt, cnt_eq  output  16 each  saturating result counters (present only with COMPARATOR_STATS_EN).

Function
REQ-014 Pair accepted on a rising clk edge where rst_n=1 and in_valid=1; no backpressure, one pair per cycle maximum.
REQ-015 Latency exactly 1 cycle: greater/lesser/equal/out_valid reflect the pair accepted at the preceding edge.
REQ-016 After the first accepted pair, exactly one of greater/lesser/equal is 1 (one-hot) at all times.
REQ-017 When in_valid=0, greater/lesser/equal hold their last values; out_valid drives 0.
REQ-018 SIGNED=1: MSB is the sign bit (e.g. WIDTH=4: 4'b1000 = -8 < 4'b0111 = +7); SIGNED=0: plain unsigned magnitude.
REQ-019 WIDTH=1, SIGNED=1: 1'b1 = -1 < 1'b0 = 0.
REQ-020 X/Z on a or b while in_valid=1 is illegal; behaviour undefined, no recovery required beyond next valid pair.

Reset
REQ-021 rst_n=0 at a rising edge: greater=0, lesser=0, equal=0, out_valid=0, all counters=0; in_valid ignored that cycle.
REQ-022 Reset asserted while a pair is in flight discards it; no out_valid pulse follows.
REQ-023 First pair accepted after rst_n deasserts produces a normal 1-cycle result.

Configuration
REQ-024 Macro COMPARATOR_STATS_EN defined: stats_clr, cnt_gt, cnt_lt, cnt_eq exist; each accepted pair increments the matching counter at the same edge the result registers update.
REQ-025 Counters saturate at 16'hFFFF and never wrap.
REQ-026 stats_clr=1 zeroes all three counters; coincident accepted pair is not counted (clear wins).
REQ-027 Macro COMPARATOR_STATS_EN undefined: those four ports and all counter logic are absent; compare behaviour unchanged.

Structure
REQ-028 Shared package comparator_pkg holds typedef enum cmp_res_e {CMP_EQ, CMP_LT, CMP_GT} and localparam CNT_W = 16.
REQ-029 Combinational compare lives in sub-module comparator_core (a, b, SIGNED -> cmp_res_e); comparator adds registers, valid, and stats.

Verification
REQ-030 WIDTH=1 unsigned, all four pairs (0,0),(0,1),(1,0),(1,1) -> next cycle equal, lesser, greater, equal respectively, out_valid=1 each.
REQ-031 WIDTH=8 SIGNED=1, a=8'h80, b=8'h7F -> lesser=1; SIGNED=0 same operands -> greater=1.
REQ-032 Accept a=5,b=3 then in_valid=0 three cycles -> greater stays 1, out_valid 1 for exactly one cycle then 0.
REQ-033 rst_n=0 in the cycle after accepting a=2,b=2 -> all outputs 0, no out_valid pulse.
REQ-034 STATS_EN: 70000 equal pairs -> cnt_eq=16'hFFFF; then stats_clr with coincident pair -> all counters 0.
REQ-035 Random 10000 pairs, WIDTH=16 both SIGNED values -> one-hot outputs match scoreboard every cycle.
